// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester round-robin arbiter/sequencer in front of the single-port
//   data memory. m0 is the CPU load/store unit, m1 is the program/data loader.
//   One access is in flight at a time: IDLE -> ACCESS -> RESP. RESP samples
//   requests just as IDLE does, so a held request gets one grant every two cycles.
//   Out-of-range addresses never reach the memory; they complete with an error.
// Ports
//   clk, rst              clock (posedge state), asynchronous active-high reset
//   mX_req/we/addr/wdata  request, access type (1 = write), word address, write data
//   mX_gnt                one-cycle pulse: request accepted (the ACCESS cycle)
//   mX_done/err           one-cycle pulses: access complete / address out of range
//   mX_rdata              read data, held until the next read completes
//   mem_addr/din/we/re    to the memory (it commits writes on negedge)
//   mem_dout              read data from the memory
module mem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Full-width unsigned compare: no truncation of high address bits.
  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return (a < DEPTH_A);
  endfunction

  state_t        state_r, state_s;
  logic          ptr_r, ptr_s;        // 0: m0 wins a tie, 1: m1 wins a tie
  logic          win_r, win_s;        // requester owning the current access
  logic          acc_we_r, acc_we_s;
  logic          acc_oor_r, acc_oor_s;

  logic          any_req_s, pick_s, sel_we_s, sel_ok_s;
  logic [AW-1:0] sel_addr_s, addr_s;
  logic [DW-1:0] sel_wdata_s, din_s;
  logic          mem_we_s, mem_re_s;
  logic          m0_gnt_s, m1_gnt_s, m0_done_s, m1_done_s, m0_err_s, m1_err_s;
  logic [DW-1:0] m0_rdata_s, m1_rdata_s;

  // Candidate winner and its request fields.
  always_comb begin
    any_req_s   = m0_req | m1_req;
    pick_s      = (m0_req && m1_req) ? ptr_r : m1_req;
    sel_we_s    = pick_s ? m1_we    : m0_we;
    sel_addr_s  = pick_s ? m1_addr  : m0_addr;
    sel_wdata_s = pick_s ? m1_wdata : m0_wdata;
    sel_ok_s    = addr_in_range(sel_addr_s);
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    win_s      = win_r;
    acc_we_s   = acc_we_r;
    acc_oor_s  = acc_oor_r;
    addr_s     = mem_addr;
    din_s      = mem_din;
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
    m0_gnt_s   = 1'b0;
    m1_gnt_s   = 1'b0;
    m0_done_s  = 1'b0;
    m1_done_s  = 1'b0;
    m0_err_s   = 1'b0;
    m1_err_s   = 1'b0;
    m0_rdata_s = m0_rdata;
    m1_rdata_s = m1_rdata;
    case (state_r)
      IDLE, RESP: begin
        if (any_req_s) begin
          state_s   = ACCESS;
          win_s     = pick_s;
          ptr_s     = ~pick_s;          // loser gets the next tie
          acc_we_s  = sel_we_s;
          acc_oor_s = ~sel_ok_s;
          addr_s    = sel_addr_s;
          din_s     = sel_wdata_s;
          mem_we_s  = sel_we_s & sel_ok_s;
          mem_re_s  = ~sel_we_s & sel_ok_s;
          m0_gnt_s  = ~pick_s;
          m1_gnt_s  = pick_s;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s   = RESP;
        m0_done_s = ~win_r;
        m1_done_s = win_r;
        m0_err_s  = ~win_r & acc_oor_r;
        m1_err_s  = win_r & acc_oor_r;
        if (!acc_we_r) begin
          if (win_r) begin
            m1_rdata_s = acc_oor_r ? {DW{1'b0}} : mem_dout;
          end else begin
            m0_rdata_s = acc_oor_r ? {DW{1'b0}} : mem_dout;
          end
        end else begin
          m0_rdata_s = m0_rdata;
          m1_rdata_s = m1_rdata;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= 1'b0;
      win_r     <= 1'b0;
      acc_we_r  <= 1'b0;
      acc_oor_r <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_din   <= {DW{1'b0}};
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= {DW{1'b0}};
      m1_rdata  <= {DW{1'b0}};
    end else begin
      ptr_r     <= ptr_s;
      win_r     <= win_s;
      acc_we_r  <= acc_we_s;
      acc_oor_r <= acc_oor_s;
      mem_addr  <= addr_s;
      mem_din   <= din_s;
      mem_we    <= mem_we_s;
      mem_re    <= mem_re_s;
      m0_gnt    <= m0_gnt_s;
      m1_gnt    <= m1_gnt_s;
      m0_done   <= m0_done_s;
      m1_done   <= m1_done_s;
      m0_err    <= m0_err_s;
      m1_err    <= m1_err_s;
      m0_rdata  <= m0_rdata_s;
      m1_rdata  <= m1_rdata_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural single-port memory
//   (combinational read, negedge write). Preload: word i = i, word 18 = 99.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
  logic        m0_gnt, m0_done, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
  logic        m1_gnt, m1_done, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we, mem_re;

  logic [31:0] mem [0:255];
  logic        load_req = 1'b1;
  int          checks = 0;
  int          failures = 0;

  mem_arbiter #(.DEPTH(256), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: preload on request, otherwise commit writes at negedge.
  always @(negedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 18) ? 32'd99 : 32'(i);
    end else if (mem_we && mem_addr < 32'd256) begin
      mem[mem_addr[7:0]] <= mem_din;
    end
  end

  assign mem_dout = mem_re ? mem[mem_addr[7:0]] : 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_req = 1'b1;
    tick();
    tick();
    checks++; if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_we, mem_re} !== 8'h00) begin
      failures++; $display("FAIL rst_flags got=%b exp=00000000", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_we, mem_re}); end
    checks++; if ({m0_rdata, m1_rdata, mem_addr, mem_din} !== 128'd0) begin
      failures++; $display("FAIL rst_data got=%h exp=0", {m0_rdata, m1_rdata, mem_addr, mem_din}); end
    load_req = 1'b0;
    rst = 1'b0;
  endtask

  // m0 read of preloaded word 18.
  task automatic test_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd18;
    tick();
    checks++; if ({m0_gnt, m1_gnt, mem_re, mem_we} !== 4'b1010) begin
      failures++; $display("FAIL t1_gnt got=%b exp=1010", {m0_gnt, m1_gnt, mem_re, mem_we}); end
    checks++; if (mem_addr !== 32'd18) begin
      failures++; $display("FAIL t1_addr got=%0d exp=18", mem_addr); end
    m0_req = 1'b0;
    tick();
    checks++; if ({m0_done, m0_err, m0_gnt, mem_re} !== 4'b1000) begin
      failures++; $display("FAIL t1_done got=%b exp=1000", {m0_done, m0_err, m0_gnt, mem_re}); end
    checks++; if (m0_rdata !== 32'd99) begin
      failures++; $display("FAIL t1_rdata got=%0d exp=99", m0_rdata); end
    tick();
    checks++; if (m0_done !== 1'b0) begin
      failures++; $display("FAIL t1_done_pulse got=%b exp=0", m0_done); end
  endtask

  // m1 writes word 5, then m0 reads it back.
  task automatic test_write_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd5; m1_wdata = 32'hDEADBEEF;
    tick();
    checks++; if ({m1_gnt, m0_gnt, mem_we, mem_re} !== 4'b1010) begin
      failures++; $display("FAIL t2_wgnt got=%b exp=1010", {m1_gnt, m0_gnt, mem_we, mem_re}); end
    checks++; if (mem_din !== 32'hDEADBEEF) begin
      failures++; $display("FAIL t2_din got=%h exp=deadbeef", mem_din); end
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd5;
    tick();
    checks++; if ({m1_done, m1_err, mem_we, m0_gnt} !== 4'b1000) begin
      failures++; $display("FAIL t2_wdone got=%b exp=1000", {m1_done, m1_err, mem_we, m0_gnt}); end
    checks++; if (m1_rdata !== 32'd0) begin
      failures++; $display("FAIL t2_wrdata got=%h exp=0", m1_rdata); end
    tick();
    checks++; if ({m0_gnt, mem_we, mem_re} !== 3'b101) begin
      failures++; $display("FAIL t2_rgnt got=%b exp=101", {m0_gnt, mem_we, mem_re}); end
    m0_req = 1'b0;
    tick();
    checks++; if (m0_done !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL t2_rdata got=%b/%h exp=1/deadbeef", m0_done, m0_rdata); end
  endtask

  // Both requesting and held after reset: strict alternation every 2 cycles.
  task automatic test_contention();
    logic [1:0] exp_g, exp_d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_g = (c == 1 || c == 5) ? 2'b01 : ((c == 3 || c == 7) ? 2'b10 : 2'b00);
      exp_d = (c == 2 || c == 6) ? 2'b01 : ((c == 4 || c == 8) ? 2'b10 : 2'b00);
      checks++; if ({m1_gnt, m0_gnt} !== exp_g) begin
        failures++; $display("FAIL t3_gnt c%0d got=%b exp=%b", c, {m1_gnt, m0_gnt}, exp_g); end
      checks++; if ({m1_done, m0_done} !== exp_d) begin
        failures++; $display("FAIL t3_done c%0d got=%b exp=%b", c, {m1_done, m0_done}, exp_d); end
      if (c == 8) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end
    checks++; if (m0_rdata !== 32'd1 || m1_rdata !== 32'd2) begin
      failures++; $display("FAIL t3_rdata got=%0d/%0d exp=1/2", m0_rdata, m1_rdata); end
    tick();
  endtask

  // Out-of-range accesses complete with err and never touch memory.
  task automatic test_out_of_range();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd256; m0_wdata = 32'd7;
    tick();
    checks++; if ({m0_gnt, mem_we, mem_re} !== 3'b100) begin
      failures++; $display("FAIL t4_gnt got=%b exp=100", {m0_gnt, mem_we, mem_re}); end
    m0_req = 1'b0;
    tick();
    checks++; if ({m0_done, m0_err, mem_we, m0_rdata} !== {3'b110, 32'd1}) begin
      failures++; $display("FAIL t4_err got=%b/%b/%b/%0d exp=1/1/0/1", m0_done, m0_err, mem_we, m0_rdata); end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd0;
    tick();
    m0_req = 1'b0;
    tick();
    checks++; if ({m0_done, m0_err, m0_rdata} !== {2'b10, 32'd0}) begin
      failures++; $display("FAIL t4_rd0 got=%b/%b/%h exp=1/0/0", m0_done, m0_err, m0_rdata); end
    // High address bits must not alias onto word 18.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0012;
    tick();
    checks++; if ({m1_gnt, mem_re} !== 2'b10) begin
      failures++; $display("FAIL t4_hi_gnt got=%b exp=10", {m1_gnt, mem_re}); end
    m1_addr = 32'd255;
    tick();
    checks++; if ({m1_done, m1_err, m1_rdata} !== {2'b11, 32'd0}) begin
      failures++; $display("FAIL t4_hi_err got=%b/%b/%h exp=1/1/0", m1_done, m1_err, m1_rdata); end
    tick();
    m1_req = 1'b0;
    tick();
    checks++; if ({m1_done, m1_err, m1_rdata} !== {2'b10, 32'd255}) begin
      failures++; $display("FAIL t4_255 got=%b/%b/%0d exp=1/0/255", m1_done, m1_err, m1_rdata); end
  endtask

  // Reset in the middle of a write's ACCESS cycle, before the negedge.
  task automatic test_reset_abort();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd3; m1_wdata = 32'h55;
    tick();
    checks++; if ({m1_gnt, mem_we} !== 2'b11) begin
      failures++; $display("FAIL t5_pre got=%b exp=11", {m1_gnt, mem_we}); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({m1_gnt, m1_done, mem_we, mem_re, mem_addr, mem_din, m1_rdata} !== 100'd0) begin
      failures++; $display("FAIL t5_rst got=%b%b%b%b/%h/%h/%h exp=0", m1_gnt, m1_done, mem_we, mem_re, mem_addr, mem_din, m1_rdata); end
    m1_req = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (mem[3] !== 32'd3) begin
      failures++; $display("FAIL t5_word3 got=%h exp=3", mem[3]); end
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd3;
    tick();
    checks++; if ({m0_gnt, m1_done} !== 2'b10) begin
      failures++; $display("FAIL t5_idle got=%b exp=10", {m0_gnt, m1_done}); end
    m0_req = 1'b0;
    tick();
    checks++; if ({m0_done, m1_done, m0_rdata} !== {2'b10, 32'd3}) begin
      failures++; $display("FAIL t5_rd3 got=%b/%b/%0d exp=1/0/3", m0_done, m1_done, m0_rdata); end
  endtask

  // m1 alone, back-to-back reads of words 0..3.
  task automatic test_back_to_back();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({m1_gnt, m0_gnt, m1_done} !== 3'b100) begin
        failures++; $display("FAIL t6_gnt%0d got=%b exp=100", i, {m1_gnt, m0_gnt, m1_done}); end
      m1_addr = 32'(i + 1);
      if (i == 3) m1_req = 1'b0;
      tick();
      checks++; if ({m1_done, m1_gnt, m0_done} !== 3'b100 || m1_rdata !== 32'(i)) begin
        failures++; $display("FAIL t6_rd%0d got=%b/%0d exp=100/%0d", i, {m1_done, m1_gnt, m0_done}, m1_rdata, i); end
    end
    tick();
    checks++; if ({m1_gnt, m1_done} !== 2'b00) begin
      failures++; $display("FAIL t6_quiet got=%b exp=00", {m1_gnt, m1_done}); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
